// File: rtl/neuromorphic_x1_arbiter.sv
// neuromorphic_x1_arbiter
// Two-requester round-robin arbiter and transaction sequencer in front of the
// NEUROMORPHIC_X1 functional port. One transaction is in flight at a time: the
// granted request is registered onto EN/R_WB/AD/DI/SEL and held until func_ack,
// after which a single-cycle req_ack (with read data on req_do) is returned.
// Optional build macro: NX1_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles with a sticky timeout_err flag.
module neuromorphic_x1_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rw,
  input  logic [63:0] req_ad,
  input  logic [63:0] req_di,
  input  logic [7:0]  req_sel,
  output logic [1:0]  req_ack,
  output logic [31:0] req_do,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] AD,
  output logic [31:0] DI,
  output logic [3:0]  SEL,
  input  logic [31:0] DO,
  input  logic        func_ack,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic        en_q, en_d;
  logic        rwb_q, rwb_d;
  logic [31:0] ad_q, ad_d;
  logic [31:0] di_q, di_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] do_q, do_d;

  // Arbitration result and the selected requester's fields
  logic        grant_valid;
  logic        grant_idx;
  logic        g_rw;
  logic [31:0] g_ad;
  logic [31:0] g_di;
  logic [3:0]  g_sel;

  // Abort request from the watchdog (constant 0 when the watchdog is not built)
  logic        timeout_hit;

  // Round-robin pick: a lone requester wins, on contention the one not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    case (req)
      2'b01: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_idx   = ~last_grant_q;
      end
      default: begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
      end
    endcase
  end

  // Demultiplex the packed request fields of the winning requester
  always_comb begin
    g_rw  = 1'b0;
    g_ad  = 32'd0;
    g_di  = 32'd0;
    g_sel = 4'd0;
    if (grant_idx) begin
      g_rw  = req_rw[1];
      g_ad  = req_ad[63:32];
      g_di  = req_di[63:32];
      g_sel = req_sel[7:4];
    end else begin
      g_rw  = req_rw[0];
      g_ad  = req_ad[31:0];
      g_di  = req_di[31:0];
      g_sel = req_sel[3:0];
    end
  end

`ifdef NX1_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // Watchdog: cleared at grant, counts BUSY cycles without func_ack; func_ack has priority
  always_comb begin
    to_cnt_d    = to_cnt_q;
    to_err_d    = to_err_q;
    timeout_hit = 1'b0;
    if (state_q == S_IDLE) begin
      if (grant_valid) begin
        to_cnt_d = {TO_W{1'b0}};
      end else begin
        to_cnt_d = to_cnt_q;
      end
    end else if ((state_q == S_BUSY) && !func_ack) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
        to_err_d    = 1'b1;
        to_cnt_d    = {TO_W{1'b0}};
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      to_cnt_q <= {TO_W{1'b0}};
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Sequencer next state: grant in IDLE, hold the bus in BUSY, acknowledge in DONE
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    en_d         = en_q;
    rwb_d        = rwb_q;
    ad_d         = ad_q;
    di_d         = di_q;
    sel_d        = sel_q;
    ack_d        = 2'b00;
    do_d         = do_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d      = S_BUSY;
          gnt_d        = grant_idx;
          last_grant_d = grant_idx;
          en_d         = 1'b1;
          rwb_d        = g_rw;
          ad_d         = g_ad;
          if (g_rw) begin
            // Reads present a neutral data/byte-select pattern to the macro
            di_d  = 32'd0;
            sel_d = 4'hF;
          end else begin
            di_d  = g_di;
            sel_d = g_sel;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (func_ack) begin
          state_d = S_DONE;
          en_d    = 1'b0;
          if (gnt_q) begin
            ack_d = 2'b10;
          end else begin
            ack_d = 2'b01;
          end
          if (rwb_q) begin
            do_d = DO;
          end else begin
            do_d = do_q;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          en_d    = 1'b0;
          if (gnt_q) begin
            ack_d = 2'b10;
          end else begin
            ack_d = 2'b01;
          end
          do_d = 32'hDEAD_BEEF;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs; reset leaves requester 0 first in line
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      en_q         <= 1'b0;
      rwb_q        <= 1'b0;
      ad_q         <= 32'd0;
      di_q         <= 32'd0;
      sel_q        <= 4'd0;
      ack_q        <= 2'b00;
      do_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      en_q         <= en_d;
      rwb_q        <= rwb_d;
      ad_q         <= ad_d;
      di_q         <= di_d;
      sel_q        <= sel_d;
      ack_q        <= ack_d;
      do_q         <= do_d;
    end
  end

  assign EN      = en_q;
  assign R_WB    = rwb_q;
  assign AD      = ad_q;
  assign DI      = di_q;
  assign SEL     = sel_q;
  assign req_ack = ack_q;
  assign req_do  = do_q;
  assign busy    = (state_q != S_IDLE);

endmodule
